// File: rtl/square_wave_meter.sv
// Square-wave period / high-time meter on a sampled 8-bit waveform.
// Build option SQW_METER_HYST_EN: hysteresis comparator (THRESH_HI/THRESH_LO) instead of a mid-scale slicer.

module square_wave_meter #(
   parameter int unsigned CNT_BITS  = 32,
   parameter logic [31:0] TIMEOUT   = 32'd50000000,
   parameter logic [7:0]  THRESH_HI = 8'hC0,
   parameter logic [7:0]  THRESH_LO = 8'h40
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          adc_in,
   output logic [CNT_BITS-1:0] period,
   output logic [CNT_BITS-1:0] high_time,
   output logic                meas_valid,
   output logic                no_signal
);

   // state | meaning
   // IDLE  | disarmed; waiting for a rising edge to start counting
   // HIGH  | counting, waveform above threshold since the last rise
   // LOW   | counting, waveform below threshold; next rise closes a period

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [CNT_BITS-1:0] TIMEOUT_C = CNT_BITS'(TIMEOUT);

   state_t              state;
   state_t              state_nxt;
   logic [7:0]          adc_q;
   logic                level;
   logic                level_d;
   logic                rise;
   logic                fall;
   logic [CNT_BITS-1:0] cnt;
   logic [CNT_BITS-1:0] hi_cnt;
   logic [CNT_BITS-1:0] cap_period;
   logic [CNT_BITS-1:0] cap_high;
   logic [1:0]          stb;
   logic                arm_cnt;
   logic                latch_hi;
   logic                capture;
   logic                timeout_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         adc_q   <= '0;
         level_d <= 1'b0;
      end else begin
         adc_q   <= adc_in;
         level_d <= level;
      end
   end

`ifdef SQW_METER_HYST_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         level <= 1'b0;
      end else if (adc_q >= THRESH_HI) begin
         level <= 1'b1;
      end else if (adc_q <= THRESH_LO) begin
         level <= 1'b0;
      end
   end
`else
   // Equivalent to adc_q[7]; written as a compare so every sample bit is consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         level <= 1'b0;
      end else begin
         level <= (adc_q >= 8'h80);
      end
   end
`endif

   assign rise = level & ~level_d;
   assign fall = ~level & level_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      arm_cnt     = 1'b0;
      latch_hi    = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      unique case (state)
         IDLE: begin
            if (rise) begin
               state_nxt = HIGH;
               arm_cnt   = 1'b1;
            end
         end
         HIGH: begin
            if (cnt >= TIMEOUT_C) begin
               state_nxt   = IDLE;
               timeout_hit = 1'b1;
            end else if (fall) begin
               state_nxt = LOW;
               latch_hi  = 1'b1;
            end
         end
         LOW: begin
            if (cnt >= TIMEOUT_C) begin
               state_nxt   = IDLE;
               timeout_hit = 1'b1;
            end else if (rise) begin
               state_nxt = HIGH;
               capture   = 1'b1;
               arm_cnt   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The capture is delayed two cycles so meas_valid lands 4 clocks after the crossing sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         hi_cnt     <= '0;
         cap_period <= '0;
         cap_high   <= '0;
         stb        <= 2'b00;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         no_signal  <= 1'b1;
      end else begin
         if (arm_cnt) begin
            cnt <= {{(CNT_BITS-1){1'b0}}, 1'b1};
         end else if ((state != IDLE) && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
         end
         if (latch_hi) begin
            hi_cnt <= cnt;
         end
         if (capture) begin
            cap_period <= cnt;
            cap_high   <= hi_cnt;
         end
         stb        <= {stb[0], capture};
         meas_valid <= stb[1];
         if (stb[1]) begin
            period    <= cap_period;
            high_time <= cap_high;
            no_signal <= 1'b0;
         end
         if (timeout_hit) begin
            period    <= '0;
            high_time <= '0;
            no_signal <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_square_wave_meter.sv
// Bench for square_wave_meter: directed waveforms plus random square waves,
// compared every cycle against an edge-timing reference model.

module tb_square_wave_meter;

   localparam int          NC      = 4096;
   localparam int          CB      = 16;
   localparam int          TMO     = 100;
   localparam logic [7:0]  THR_HI  = 8'hC0;
   localparam logic [7:0]  THR_LO  = 8'h40;

   logic          clk;
   logic          reset;
   logic [7:0]    adc_in;
   logic [CB-1:0] period;
   logic [CB-1:0] high_time;
   logic          meas_valid;
   logic          no_signal;

   square_wave_meter #(
      .CNT_BITS (CB),
      .TIMEOUT  (32'd100)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .adc_in     (adc_in),
      .period     (period),
      .high_time  (high_time),
      .meas_valid (meas_valid),
      .no_signal  (no_signal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] stim [NC];
   bit         rstv [NC];
   bit         el   [NC];
   int         e_mv [NC];
   int         e_per[NC];
   int         e_hi [NC];
   int         e_ns [NC];
   int         n_st;
   int         n_chk;
   int         n_pass;
   int         n_fail;

   task automatic push(input logic [7:0] v, input int len, input bit r);
      for (int i = 0; i < len; i++) begin
         if (n_st < NC) begin
            stim[n_st] = v;
            rstv[n_st] = r;
            n_st++;
         end
      end
   endtask

   task automatic check(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, e, obs, exp);
      end
   endtask

   // Reference: a crossing sampled at s is seen by the meter at s+2 and reported at s+4;
   // period/high_time are distances between seen edges; TMO cycles after arming with no
   // closing rise the measurement is abandoned.
   task automatic build_model();
      bit armed, fallen, ns, rise, fall, mv;
      int arm_e, fall_e, last_rst, pend_e, pend_per, pend_hi, per, hi, s;
      for (int k = 0; k < n_st; k++) begin
         if (rstv[k]) el[k] = 1'b0;
`ifdef SQW_METER_HYST_EN
         else if (stim[k] >= THR_HI) el[k] = 1'b1;
         else if (stim[k] <= THR_LO) el[k] = 1'b0;
         else el[k] = (k > 0) ? el[k-1] : 1'b0;
`else
         else el[k] = (stim[k] >= 8'h80);
`endif
      end
      armed = 0; fallen = 0; ns = 1; arm_e = 0; fall_e = 0; last_rst = -1;
      pend_e = -1; pend_per = 0; pend_hi = 0; per = 0; hi = 0;
      for (int d = 0; d < n_st; d++) begin
         mv = 0;
         if (rstv[d]) begin
            armed = 0; fallen = 0; pend_e = -1; per = 0; hi = 0; ns = 1; last_rst = d;
         end else begin
            if (pend_e == d) begin
               mv = 1; per = pend_per; hi = pend_hi; ns = 0; pend_e = -1;
            end
            s    = d - 2;
            rise = (s >= 1) && (last_rst <= s) && el[s] && !el[s-1];
            fall = (s >= 1) && (last_rst <= s) && !el[s] && el[s-1];
            if (armed && (d - arm_e >= TMO)) begin
               armed = 0; per = 0; hi = 0; ns = 1;
            end else if (rise) begin
               if (!armed) begin
                  armed = 1; fallen = 0; arm_e = d;
               end else if (fallen) begin
                  pend_e = d + 2; pend_per = d - arm_e; pend_hi = fall_e - arm_e;
                  arm_e = d; fallen = 0;
               end
            end else if (fall && armed && !fallen) begin
               fallen = 1; fall_e = d;
            end
         end
         e_mv[d] = mv; e_per[d] = per; e_hi[d] = hi; e_ns[d] = ns;
      end
   endtask

   initial begin
      int m_s1, m_q0, m_t0, m_u, m_rst, len;
      n_st = 0; n_chk = 0; n_pass = 0; n_fail = 0;
      reset  = 1'b1;
      adc_in = 8'h00;

      // reset, then 10-high / 30-low waveform
      push(8'h00, 2, 1);
      push(8'h00, 8, 0);
      m_s1 = n_st;
      for (int i = 0; i < 6; i++) begin
         push(8'hFF, 10, 0);
         push(8'h00, 30, 0);
      end
      // minimum 1/1 waveform
      m_q0 = n_st;
      for (int i = 0; i < 20; i++) begin
         push(8'hFF, 1, 0);
         push(8'h00, 1, 0);
      end
      // stuck high -> timeout
      push(8'h00, 5, 0);
      m_t0 = n_st;
      push(8'hFF, 150, 0);
      push(8'h00, 30, 0);
      // mid-band excursion: an edge only without hysteresis
      m_u = n_st;
      push(8'h90, 20, 0);
      push(8'h00, 20, 0);
      push(8'hFF, 10, 0);
      push(8'h00, 150, 0);
      // reset pulse in the middle of a high phase
      push(8'h00, 20, 0);
      for (int i = 0; i < 3; i++) begin
         push(8'hFF, 10, 0);
         push(8'h00, 30, 0);
      end
      push(8'hFF, 5, 0);
      m_rst = n_st;
      push(8'hFF, 1, 1);
      push(8'hFF, 5, 0);
      for (int i = 0; i < 4; i++) begin
         push(8'h00, 30, 0);
         push(8'hFF, 10, 0);
      end
      push(8'h00, 30, 0);
      // random square waves, occasionally with gaps long enough to time out
      for (int i = 0; i < 40; i++) begin
         len = $urandom_range(25, 1);
         push(8'($urandom_range(8'hFF, 8'hC0)), len, 0);
         len = ($urandom_range(9, 0) == 0) ? $urandom_range(130, 100) : $urandom_range(25, 1);
         push(8'($urandom_range(8'h3F, 8'h00)), len, 0);
      end
      push(8'h00, 20, 0);

      build_model();

      for (int e = 0; e < n_st; e++) begin
         adc_in = stim[e];
         reset  = rstv[e];
         @(posedge clk);
         #1;
         check("meas_valid", e, 32'(meas_valid), 32'(e_mv[e]));
         check("no_signal",  e, 32'(no_signal),  32'(e_ns[e]));
         check("period",     e, 32'(period),     32'(e_per[e]));
         check("high_time",  e, 32'(high_time),  32'(e_hi[e]));

         if (e == 1) begin
            check("rst_period", e, 32'(period), 32'd0);
            check("rst_no_signal", e, 32'(no_signal), 32'd1);
         end
         if (e == m_s1 + 3) begin
            check("arm_only_mv", e, 32'(meas_valid), 32'd0);
            check("arm_only_ns", e, 32'(no_signal), 32'd1);
         end
         if (e == m_s1 + 43) check("lat_early_mv", e, 32'(meas_valid), 32'd0);
         if (e == m_s1 + 44) begin
            check("lat_mv", e, 32'(meas_valid), 32'd1);
            check("w40_period", e, 32'(period), 32'd40);
            check("w40_high", e, 32'(high_time), 32'd10);
            check("w40_ns", e, 32'(no_signal), 32'd0);
         end
         if (e == m_s1 + 84) check("w40_period2", e, 32'(period), 32'd40);
         if ((e == m_q0 + 6) || (e == m_q0 + 8)) begin
            check("min_mv", e, 32'(meas_valid), 32'd1);
            check("min_period", e, 32'(period), 32'd2);
            check("min_high", e, 32'(high_time), 32'd1);
         end
         if (e == m_q0 + 7) check("min_gap_mv", e, 32'(meas_valid), 32'd0);
         if (e == m_t0 + 101) begin
            check("pre_tmo_ns", e, 32'(no_signal), 32'd0);
            check("pre_tmo_period", e, 32'(period), 32'd7);
         end
         if (e == m_t0 + 102) begin
            check("tmo_ns", e, 32'(no_signal), 32'd1);
            check("tmo_period", e, 32'(period), 32'd0);
            check("tmo_high", e, 32'(high_time), 32'd0);
            check("tmo_mv", e, 32'(meas_valid), 32'd0);
         end
         if (e == m_u + 44) begin
`ifdef SQW_METER_HYST_EN
            check("hyst_mv", e, 32'(meas_valid), 32'd0);
`else
            check("hyst_mv", e, 32'(meas_valid), 32'd1);
            check("hyst_period", e, 32'(period), 32'd40);
            check("hyst_high", e, 32'(high_time), 32'd20);
`endif
         end
         if (e == m_rst) begin
            check("midrst_period", e, 32'(period), 32'd0);
            check("midrst_high", e, 32'(high_time), 32'd0);
            check("midrst_ns", e, 32'(no_signal), 32'd1);
         end
         if (e == m_rst + 40) begin
            check("postrst_mv", e, 32'(meas_valid), 32'd1);
            check("postrst_period", e, 32'(period), 32'd35);
            check("postrst_high", e, 32'(high_time), 32'd5);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
